// File: rtl/recfg_pkg.sv
// -----------------------------------------------------------------------------
// recfg_pkg
// Shared types and arithmetic helpers for the reconfigurable tile array.
//   mode_e      : operation codes, encoded as the 3-bit mode port value
//   state_e     : sequencing states of the tile
//   is_matrix() : 1 for operations that drain a full COLS-beat matrix
//   sat_range() : clamp a wide signed value to a signed dw-bit range
//   rescale_sat(): round half up, drop frac fractional bits, then clamp
// The helpers work on 64-bit signed values so that one definition serves every
// parameterisation (products, sums and accumulators all fit below 64 bits).
// -----------------------------------------------------------------------------
package recfg_pkg;

    typedef enum logic [2:0] {
        MAC       = 3'b000,
        EWM_BCAST = 3'b001,
        EWM_VEC   = 3'b010,
        OUTER     = 3'b011,
        EWA_VEC   = 3'b100,
        EWA_MAT   = 3'b101,
        EWM_MAT   = 3'b110,
        RSVD      = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    function automatic logic is_matrix(input mode_e m);
        return (m == EWM_BCAST) || (m == OUTER) || (m == EWA_MAT) || (m == EWM_MAT);
    endfunction

    function automatic logic signed [63:0] sat_range(input logic signed [63:0] v,
                                                     input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Arithmetic shift after adding half an LSB gives round-half-up for both
    // signs (e.g. -0.5 LSB rounds to 0).
    function automatic logic signed [63:0] rescale_sat(input logic signed [63:0] v,
                                                       input int frac,
                                                       input int dw);
        logic signed [63:0] r;
        if (frac == 0) begin
            return sat_range(v, dw);
        end
        r = (v + (64'sd1 <<< (frac - 1))) >>> frac;
        return sat_range(r, dw);
    endfunction

endpackage

// File: rtl/recfg_pe.sv
// -----------------------------------------------------------------------------
// recfg_pe
// One combinational processing element: a rounded/saturated fixed-point
// product and a saturated sum of the same two operands.
//   a_i, b_i : signed DATA_WIDTH operands with FRAC_BITS fractional bits
//   prod_o   : a_i*b_i rescaled back to the operand format
//   sum_o    : a_i+b_i clamped to the operand range
// -----------------------------------------------------------------------------
module recfg_pe
    import recfg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] prod_o,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    logic signed [2*DATA_WIDTH-1:0] prod_full;
    logic signed [DATA_WIDTH:0]     sum_full;

    assign prod_full = a_i * b_i;
    assign sum_full  = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};

    assign prod_o = DATA_WIDTH'(rescale_sat(
        {{(64-2*DATA_WIDTH){prod_full[2*DATA_WIDTH-1]}}, prod_full},
        FRAC_BITS, DATA_WIDTH));

    assign sum_o = DATA_WIDTH'(sat_range(
        {{(63-DATA_WIDTH){sum_full[DATA_WIDTH]}}, sum_full},
        DATA_WIDTH));

endmodule

// File: rtl/recfg_tile_array.sv
// -----------------------------------------------------------------------------
// recfg_tile_array
// ROWS x COLS reconfigurable Q-format compute tile with IDLE/LOAD/COMPUTE/DRAIN
// sequencing and valid/ready streams.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous abort to IDLE (beats start and handshakes)
//   start, mode       : operation request, sampled in IDLE only
//   busy, mode_err    : not-IDLE flag, one-cycle pulse on reserved mode
//   in_valid/in_ready : load handshake, beat k carries column k of A and B
//   in_a, in_b, bias  : ROWS lanes of DATA_WIDTH; bias used by MAC only
//   bias_en           : add bias (sampled on the last load beat)
//   out_valid/out_ready, out_data, out_last : drain stream, one column per beat
//   out_is_matrix     : current operation drains COLS beats
// Elementwise results come from a ROWS x COLS grid of recfg_pe in one cycle;
// MAC walks one column per cycle through a bank of full-precision accumulators.
// -----------------------------------------------------------------------------
module recfg_tile_array
    import recfg_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       start,
    input  logic [2:0]                 mode,
    output logic                       busy,
    output logic                       mode_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_a,
    input  logic [ROWS*DATA_WIDTH-1:0] in_b,
    input  logic [ROWS*DATA_WIDTH-1:0] bias,
    input  logic                       bias_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic                       out_last,
    output logic                       out_is_matrix
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(COLS - 1);

    // control registers
    state_e          state_q;
    mode_e           mode_q;
    logic [CW-1:0]   cnt_q;       // load beat, MAC column or drain beat
    logic            busy_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            is_mat_q;
    logic            mode_err_q;

    // operand, result and accumulator storage (contents don't-care after reset)
    logic signed [DATA_WIDTH-1:0] a_q [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_q [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] r_q [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_q [ROWS];

    logic signed [ACC_WIDTH-1:0]  acc_sum  [ROWS];
    logic signed [ACC_WIDTH-1:0]  bias_ext [ROWS];
    logic signed [DATA_WIDTH-1:0] mac_res  [ROWS];
    logic signed [DATA_WIDTH-1:0] pe_prod  [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] pe_sum   [ROWS][COLS];

    logic load_fire;
    logic load_last;
    logic mac_step;
    logic compute_done;
    logic use_sum;

    assign load_fire    = (state_q == LOAD) && in_valid && !flush;
    assign load_last    = load_fire && (cnt_q == LAST_IDX);
    assign mac_step     = (state_q == COMPUTE) && (mode_q == MAC) && !flush;
    assign compute_done = (state_q == COMPUTE) && !flush &&
                          ((mode_q != MAC) || (cnt_q == LAST_IDX));
    assign use_sum      = (mode_q == EWA_VEC) || (mode_q == EWA_MAT);

    assign busy          = busy_q;
    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_is_matrix = is_mat_q;
    assign mode_err      = mode_err_q;

    genvar gi, gj;

    // MAC lane datapath: full-precision product of the current column, added
    // into the accumulator; the result taps the sum so the final column lands
    // in r_q on the same edge that leaves COMPUTE.
    for (gi = 0; gi < ROWS; gi++) begin : g_mac
        logic signed [2*DATA_WIDTH-1:0] mac_prod;
        logic [DATA_WIDTH-1:0]          bias_lane;

        assign bias_lane = bias[gi*DATA_WIDTH +: DATA_WIDTH];
        assign mac_prod  = a_q[gi][cnt_q] * b_q[0][cnt_q];
        assign acc_sum[gi] = acc_q[gi] +
            {{(ACC_WIDTH-2*DATA_WIDTH){mac_prod[2*DATA_WIDTH-1]}}, mac_prod};
        // bias is a Q value; shift it up to the product's fractional alignment
        assign bias_ext[gi] = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias_lane[DATA_WIDTH-1]}},
                               bias_lane, {FRAC_BITS{1'b0}}};
        assign mac_res[gi] = DATA_WIDTH'(rescale_sat(
            {{(64-ACC_WIDTH){acc_sum[gi][ACC_WIDTH-1]}}, acc_sum[gi]},
            FRAC_BITS, DATA_WIDTH));

        assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_valid_q ? r_q[gi][cnt_q] : '0;
    end

    // PE grid. Vector modes only consume column 0, which the default
    // A[i][j]/B[i][j] routing already serves.
    for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
        for (gj = 0; gj < COLS; gj++) begin : g_pe_col
            logic signed [DATA_WIDTH-1:0] op_a;
            logic signed [DATA_WIDTH-1:0] op_b;

            always_comb begin
                op_a = a_q[gi][gj];
                op_b = b_q[gi][gj];
                if (mode_q == EWM_BCAST) begin
                    op_b = b_q[gi][0];
                end else if (mode_q == OUTER) begin
                    op_a = a_q[gi][0];
                    op_b = b_q[0][gj];
                end
            end

            recfg_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .FRAC_BITS  (FRAC_BITS)
            ) u_pe (
                .a_i    (op_a),
                .b_i    (op_b),
                .prod_o (pe_prod[gi][gj]),
                .sum_o  (pe_sum[gi][gj])
            );
        end
    end

    // storage updates
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int i = 0; i < ROWS; i++) begin
                a_q[i][cnt_q] <= in_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_q[i][cnt_q] <= in_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (load_last) begin
            for (int i = 0; i < ROWS; i++) begin
                acc_q[i] <= bias_en ? bias_ext[i] : '0;
            end
        end else if (mac_step) begin
            for (int i = 0; i < ROWS; i++) begin
                acc_q[i] <= acc_sum[i];
            end
        end
        if (compute_done) begin
            if (mode_q == MAC) begin
                for (int i = 0; i < ROWS; i++) begin
                    r_q[i][0] <= mac_res[i];
                end
            end else begin
                for (int i = 0; i < ROWS; i++) begin
                    for (int j = 0; j < COLS; j++) begin
                        r_q[i][j] <= use_sum ? pe_sum[i][j] : pe_prod[i][j];
                    end
                end
            end
        end
    end

    // sequencer with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MAC;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            is_mat_q    <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            mode_err_q <= 1'b0;
            if (flush) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                busy_q      <= 1'b0;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                is_mat_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (mode == 3'b111) begin
                                mode_err_q <= 1'b1;
                            end else begin
                                state_q    <= LOAD;
                                mode_q     <= mode_e'(mode);
                                cnt_q      <= '0;
                                busy_q     <= 1'b1;
                                in_ready_q <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (in_valid) begin
                            if (cnt_q == LAST_IDX) begin
                                state_q    <= COMPUTE;
                                cnt_q      <= '0;
                                in_ready_q <= 1'b0;
                                is_mat_q   <= is_matrix(mode_q);
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    COMPUTE: begin
                        if (compute_done) begin
                            state_q     <= DRAIN;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= !is_matrix(mode_q) || (COLS == 1);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    DRAIN: begin
                        if (out_ready) begin
                            if (out_last_q) begin
                                state_q     <= IDLE;
                                cnt_q       <= '0;
                                busy_q      <= 1'b0;
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                is_mat_q    <= 1'b0;
                            end else begin
                                cnt_q      <= cnt_q + CW'(1);
                                out_last_q <= ((cnt_q + CW'(1)) == LAST_IDX);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_recfg_tile_array.sv
module tb_recfg_tile_array;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic        busy;
    logic        mode_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [R*DW-1:0] in_a = '0;
    logic [R*DW-1:0] in_b = '0;
    logic [R*DW-1:0] bias = '0;
    logic        bias_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [R*DW-1:0] out_data;
    logic        out_last;
    logic        out_is_matrix;

    recfg_tile_array #(
        .ROWS       (R),
        .COLS       (C),
        .DATA_WIDTH (DW),
        .FRAC_BITS  (8),
        .ACC_WIDTH  (40)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .start         (start),
        .mode          (mode),
        .busy          (busy),
        .mode_err      (mode_err),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .bias          (bias),
        .bias_en       (bias_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_is_matrix (out_is_matrix)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [15:0] ta  [R][C];
    logic [15:0] tbm [R][C];
    logic [15:0] er  [R][C];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic do_load(input string name, input bit stall, input bit ben,
                           input logic [15:0] bv, output int last_cyc);
        int  k = 0;
        int  guard = 0;
        bit  hs;
        last_cyc = 0;
        while (k < C && guard < 200) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < R; i++) begin
                in_a[i*DW +: DW] = ta[i][k];
                in_b[i*DW +: DW] = tbm[i][k];
                bias[i*DW +: DW] = bv;
            end
            bias_en = ben;
            @(negedge clk);
            if (guard == 0) chk({name, "_in_ready_load"}, 64'(in_ready), 64'd1);
            hs = in_valid && in_ready;
            if (hs) last_cyc = cyc;
            tick();
            if (hs) k++;
            guard++;
        end
        in_valid = 1'b0;
        bias_en  = 1'b0;
        chk({name, "_load_beats"}, 64'(k), 64'(C));
    endtask

    task automatic do_drain(input string name, input bit stall, input int nb,
                            input bit ismat, input int lat, input int last_cyc);
        int          beat = 0;
        int          guard = 0;
        int          first = -1;
        int          prev_cyc = -1;
        bit          held = 1'b0;
        logic [63:0] held_d;
        logic [63:0] ev;
        while (beat < nb && guard < 300) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (held) begin
                chk({name, "_hold"}, out_data, held_d);
                held = 1'b0;
            end
            if (guard == 0) chk({name, "_in_ready_off"}, 64'(in_ready), 64'd0);
            if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    chk({name, "_latency"}, 64'(cyc - last_cyc), 64'(lat));
                end
                if (out_ready) begin
                    for (int i = 0; i < R; i++) ev[i*DW +: DW] = er[i][beat];
                    chk({name, "_data"}, out_data, ev);
                    chk({name, "_last"}, 64'(out_last), 64'(beat == nb - 1));
                    chk({name, "_is_matrix"}, 64'(out_is_matrix), 64'(ismat));
                    if (!stall && prev_cyc >= 0) chk({name, "_thru"}, 64'(cyc - prev_cyc), 64'd1);
                    $display("%s beat %0d data=%h last=%0d", name, beat, out_data, out_last);
                    prev_cyc = cyc;
                    beat++;
                end else begin
                    held   = 1'b1;
                    held_d = out_data;
                end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        chk({name, "_beats"}, 64'(beat), 64'(nb));
        @(negedge clk);
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
        chk({name, "_idle_valid"}, 64'(out_valid), 64'd0);
        tick();
    endtask

    task automatic run(input string name, input logic [2:0] m, input bit stall,
                       input bit ben, input logic [15:0] bv, input int nb,
                       input bit ismat, input int lat);
        int lc;
        do_start(m);
        do_load(name, stall, ben, bv, lc);
        do_drain(name, stall, nb, ismat, lat, lc);
    endtask

    task automatic fill_ewm_basic();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j] = 16'h0180; tbm[i][j] = 16'h0200; er[i][j] = 16'h0300;
            end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int g;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_is_matrix", 64'(out_is_matrix), 64'd0);
        chk("rst_mode_err", 64'(mode_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // 110: 1.5 * 2.0 = 3.0 everywhere
        fill_ewm_basic();
        run("ewm_mat", 3'b110, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        // 110 saturation, positive rows 0-1, negative rows 2-3
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j]  = (i < 2) ? 16'h7F00 : 16'h8000;
                tbm[i][j] = 16'h0200;
                er[i][j]  = (i < 2) ? 16'h7FFF : 16'h8000;
            end
        run("ewm_sat", 3'b110, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        // 101 saturation
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j]  = (i < 2) ? 16'h7000 : 16'h9000;
                tbm[i][j] = (i < 2) ? 16'h7000 : 16'h9000;
                er[i][j]  = (i < 2) ? 16'h7FFF : 16'h8000;
            end
        run("ewa_sat", 3'b101, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        // MAC: 4 * (1.0 * 0.5) = 2.0, then +1.0 bias = 3.0
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j] = 16'h0100; tbm[i][j] = 16'h0080; er[i][j] = 16'h0200;
            end
        run("mac", 3'b000, 1'b0, 1'b0, 16'h0, 1, 1'b0, 5);
        for (int i = 0; i < R; i++) er[i][0] = 16'h0300;
        run("mac_bias", 3'b000, 1'b0, 1'b1, 16'h0100, 1, 1'b0, 5);

        // 011 outer product, off-column/off-row operands are junk
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j]  = (j == 0) ? 16'(i * 256) : 16'h1234;
                tbm[i][j] = (i == 0) ? 16'h0100 : 16'h0555;
                er[i][j]  = 16'(i * 256);
            end
        run("outer", 3'b011, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        // 010 vector EWM with rounding and saturation lanes
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j] = 16'h0777; tbm[i][j] = 16'h0777;
            end
        ta[0][0] = 16'h0180; tbm[0][0] = 16'h0180; er[0][0] = 16'h0240;
        ta[1][0] = 16'h0001; tbm[1][0] = 16'h0080; er[1][0] = 16'h0001;
        ta[2][0] = 16'hFFFF; tbm[2][0] = 16'h0080; er[2][0] = 16'h0000;
        ta[3][0] = 16'h8000; tbm[3][0] = 16'h8000; er[3][0] = 16'h7FFF;
        run("ewm_vec", 3'b010, 1'b0, 1'b0, 16'h0, 1, 1'b0, 2);

        // 100 vector EWA
        for (int i = 0; i < R; i++) begin
            ta[i][0] = 16'(i * 256); tbm[i][0] = 16'h0080; er[i][0] = 16'(i * 256 + 128);
        end
        run("ewa_vec", 3'b100, 1'b0, 1'b0, 16'h0, 1, 1'b0, 2);

        // 001 row broadcast
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j]  = 16'((j + 1) * 256);
                tbm[i][j] = (j == 0) ? 16'(i * 256) : 16'h0300;
                er[i][j]  = 16'((j + 1) * i * 256);
            end
        run("bcast", 3'b001, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        // handshakes: distinct data, unstalled then randomly stalled
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ta[i][j]  = 16'(256 + i * 64 + j * 16);
                tbm[i][j] = 16'h0200;
                er[i][j]  = 16'(512 + i * 128 + j * 32);
            end
        run("hs_free", 3'b110, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);
        run("hs_stall", 3'b110, 1'b1, 1'b0, 16'h0, 4, 1'b1, 2);
        run("hs_stall2", 3'b110, 1'b1, 1'b0, 16'h0, 4, 1'b1, 2);

        // reserved mode
        start = 1'b1; mode = 3'b111;
        tick();
        start = 1'b0;
        chk("rsvd_mode_err", 64'(mode_err), 64'd1);
        chk("rsvd_busy", 64'(busy), 64'd0);
        tick();
        chk("rsvd_pulse_end", 64'(mode_err), 64'd0);
        chk("rsvd_in_ready", 64'(in_ready), 64'd0);

        // flush mid-LOAD, then a clean run proves the load counter restarted
        fill_ewm_basic();
        do_start(3'b110);
        in_valid = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_load_busy", 64'(busy), 64'd0);
        chk("flush_load_in_ready", 64'(in_ready), 64'd0);
        chk("flush_load_valid", 64'(out_valid), 64'd0);
        tick();
        run("after_flush", 3'b110, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        // flush mid-DRAIN, with start and out_ready in the same cycle
        do_start(3'b110);
        do_load("fl_drain", 1'b0, 1'b0, 16'h0, lc);
        g = 0;
        while (!out_valid && g < 20) begin
            tick();
            g++;
        end
        chk("fl_drain_reached", 64'(out_valid), 64'd1);
        flush = 1'b1; out_ready = 1'b1; start = 1'b1; mode = 3'b110;
        tick();
        flush = 1'b0; out_ready = 1'b0; start = 1'b0;
        chk("fl_drain_valid", 64'(out_valid), 64'd0);
        chk("fl_drain_busy", 64'(busy), 64'd0);
        chk("fl_drain_in_ready", 64'(in_ready), 64'd0);
        tick();

        // asynchronous reset during COMPUTE
        do_start(3'b110);
        do_load("rst_mid", 1'b0, 1'b0, 16'h0, lc);
        chk("rst_mid_busy_pre", 64'(busy), 64'd1);
        chk("rst_mid_matrix_pre", 64'(out_is_matrix), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_last", 64'(out_last), 64'd0);
        chk("rst_mid_data", out_data, 64'd0);
        chk("rst_mid_matrix", 64'(out_is_matrix), 64'd0);
        chk("rst_mid_mode_err", 64'(mode_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        run("after_rst", 3'b110, 1'b0, 1'b0, 16'h0, 4, 1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recfg_tile_array.md
# recfg_tile_array

Parametrised ROWS×COLS reconfigurable compute tile: the successor to the fixed 16×16 hybrid array in the Mamba datapath. It executes the same seven Q-format operations (MAC, broadcast-EWM, vector EWM, outer product, vector/matrix EWA, matrix EWM). The differences from the 16×16 array:
- explicit IDLE/LOAD/COMPUTE/DRAIN sequencing;
- valid/ready handshakes on every stream;
- mode-dependent latency;
- round-and-saturate rescaling;
- synchronous flush.

It sits between the scan-stage buffers and the SSM state/output writers.

## Interface
- ROWS, 16, array rows (output lanes per beat)
- COLS, 16, array columns (load/drain beats per tile)
- DATA_WIDTH, 16, signed operand/result width (Q8.8)
- FRAC_BITS, 8, fractional bits of operands and results
- ACC_WIDTH, 40, MAC accumulator width; must be ≥ 2·DATA_WIDTH + clog2(COLS)+1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort to IDLE
- start  in  1  start request, sampled in IDLE only
- mode  in  3  operation code, captured on accepted start
- busy  out  1  high in any state except IDLE
- mode_err  out  1  one-cycle pulse on start with mode 3'b111
- in_valid / in_ready  in / out  1  load-beat handshake
- in_a  in  ROWS×DATA_WIDTH  column k of operand A
- in_b  in  ROWS×DATA_WIDTH  column k of operand B
- bias  in  ROWS×DATA_WIDTH  MAC bias, sampled on the last load beat when bias_en=1
- bias_en  in  1  enable bias add (MAC only)
- out_valid / out_ready  out / in  1  drain handshake
- out_data  out  ROWS×DATA_WIDTH  result column
- out_last  out  1  final drain beat
- out_is_matrix  out  1  1 for modes 001, 011, 101, 110

## Operation
State machine:
- IDLE → LOAD on start with mode ≠ 111; mode is latched.
- start with mode 111 pulses mode_err and stays in IDLE.
- start outside IDLE is ignored.

LOAD:
- in_ready = 1.
- Beat k (k = 0..COLS-1, counted by a load counter) writes A[*][k] ← in_a and B[*][k] ← in_b.
- The transfer on in_valid&in_ready with k = COLS-1 moves the block to COMPUTE.
- in_valid low stalls the load with no state change.

Arithmetic, per mode:
- 000 MAC: y[i] = Σ_j A[i][j]·B[0][j] (+ bias[i]·2^FRAC_BITS).
  - Sequential: one column per cycle, COLS cycles, ROWS accumulators in ACC_WIDTH.
  - Full-precision products carry 2·FRAC_BITS fractional bits.
- 001: R[i][j] = A[i][j]·B[i][0] (row broadcast).
- 010: y[i] = A[i][0]·B[i][0].
- 011: R[i][j] = A[i][0]·B[0][j] (outer product).
- 100: y[i] = A[i][0] + B[i][0].
- 101: R = A + B.
- 110: R = A ⊙ B.
- Elementwise modes compute all PEs in parallel in a single cycle.

Rescale, applied to every product and MAC result:
- Add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
- Saturate to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1].
- EWA sums saturate to the same range; no wrap-around anywhere.

DRAIN:
- Matrix modes: COLS beats, beat k presents R[*][k].
- Vector modes: 1 beat presenting y.
- out_data holds stable while out_valid&!out_ready.
- The last accepted beat returns to IDLE.

flush:
- Any state → IDLE next edge.
- Counters cleared; out_valid and in_ready drop; array contents are don't-care.
- flush has priority over start and over any handshake in the same cycle.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0, out_is_matrix=0, mode_err=0; state IDLE; counters 0.
- start accepted at edge t → LOAD from t+1; in_ready asserts at t+1.
- Last load beat at edge L:
  - elementwise modes: COMPUTE for 1 cycle, out_valid at L+2;
  - MAC: COMPUTE for COLS cycles, out_valid at L+COLS+1.
- Drain throughput is 1 beat/cycle with out_ready held high.
- IDLE re-entered on the edge after the out_last transfer; busy=0 one cycle later at the earliest new start.
- out_is_matrix is valid from COMPUTE through DRAIN.

## Structure
- Shared package recfg_pkg holds:
  - mode_e enum (MAC, EWM_BCAST, EWM_VEC, OUTER, EWA_VEC, EWA_MAT, EWM_MAT, RSVD);
  - state_e enum (IDLE, LOAD, COMPUTE, DRAIN);
  - function is_matrix(mode_e);
  - function rescale_sat (round/shift/saturate).
- One sub-module: recfg_pe (combinational multiply/add with rescale_sat), instantiated ROWS×COLS.
- The MAC accumulator bank and FSM live in the top level.

## Test plan
All scenarios use ROWS=COLS=4, Q8.8.
- **Mode 110:** A=0x0180 (1.5), B=0x0200 (2.0) everywhere → 4 beats of 0x0300, out_last on beat 3, out_valid 2 cycles after the last load.
- **Saturation:**
  - mode 110, A=0x7F00, B=0x0200 → 0x7FFF;
  - A=0x8000, B=0x0200 → 0x8000;
  - mode 101, 0x7000+0x7000 → 0x7FFF.
- **MAC:** A=0x0100, B row 0=0x0080 → one beat, all lanes 0x0200; repeat with bias_en=1, bias=0x0100 → 0x0300; latency is 5 cycles after the last load.
- **Outer product 011:** A[i][0]=i·0x0100, B[0][j]=0x0100 → beat j has lane i = i·0x0100; out_is_matrix=1.
- **Handshakes:** random in_valid/out_ready toggling → results identical to the unstalled run, out_data stable under stall, in_ready=0 outside LOAD.
- **Control corners:**
  - flush mid-LOAD and mid-DRAIN → IDLE next cycle, out_valid=0;
  - start with mode 111 → mode_err pulse, busy stays 0;
  - rst_n asserted mid-COMPUTE → all outputs at reset values immediately.
